sfx_sequencer: RTL and testbench
================================

Name: sfx_sequencer

Overview:
- Drives the square-wave synthesizer from the game logic: plays short fixed note sequences (sound effects) selected by an effect ID.
- Produces the synth's HALF_PERIOD, ENABLE and ADVANCE_TICK inputs.
- Sits between game-event logic (paddle/brick/wall/life-lost pulses) and the synth; one instance per audio channel.

Parameters:
- TICK_DIV, 50, CLK cycles per ADVANCE_TICK pulse (50 MHz -> 1 MHz synth tick).
- DUR_DIV, 50000, CLK cycles per duration unit (1 ms at 50 MHz).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESET_N  in  1  synchronous, active-low reset.
- TRIGGER  in  1  one-cycle request to start an effect.
- EFFECT_ID  in  2  effect selected; sampled when TRIGGER=1.
- HALF_PERIOD  out  16  synth half-period register value for the current note.
- SYNTH_ENABLE  out  1  synth ENABLE.
- ADVANCE_TICK  out  1  one-cycle tick strobe to the synth.
- BUSY  out  1  high while a sequence is playing.

Behaviour:
- Reset (RESET_N=0 at a posedge): HALF_PERIOD=0, SYNTH_ENABLE=0, ADVANCE_TICK=0, BUSY=0, state IDLE, both prescalers cleared. Reset mid-sequence aborts it.
- Tick prescaler: free-running counter 0..TICK_DIV-1. ADVANCE_TICK=1 for the single cycle where the counter equals TICK_DIV-1. It runs in all states.
- Note ROM: 16 entries indexed {EFFECT_ID, note[1:0]}. Each entry holds half[15:0], dur[7:0] and last. A half value of 0 denotes a rest: SYNTH_ENABLE stays 0 for the note's duration.
- ROM contents:
  - Effect 0 (paddle): {1135,30,last}.
  - Effect 1 (brick): {851,20}, {567,40,last}.
  - Effect 2 (wall): {1702,15,last}.
  - Effect 3 (life lost): {1135,100}, {0,50}, {1516,100}, {2272,200,last}.
- States:
  - IDLE: BUSY=0, SYNTH_ENABLE=0. TRIGGER -> LOAD with note index 0 and the ID latched.
  - LOAD (exactly 1 cycle): SYNTH_ENABLE=0, so the synth resets phase between notes. Registers HALF_PERIOD from the ROM, loads the duration counter with dur, clears the duration prescaler. -> PLAY.
  - PLAY: SYNTH_ENABLE = (HALF_PERIOD != 0). The duration prescaler counts 0..DUR_DIV-1; each wrap decrements the duration counter. At 0: last -> IDLE (SYNTH_ENABLE=0, HALF_PERIOD held); else -> LOAD with index+1.
- Timing:
  - TRIGGER at edge n: BUSY=1 and LOAD after edge n; PLAY with SYNTH_ENABLE=1 after edge n+1.
  - Each PLAY phase lasts exactly dur*DUR_DIV cycles.
- BUSY=1 in LOAD and PLAY.
- Retrigger: TRIGGER in LOAD or PLAY aborts the current sequence and goes to LOAD with the new ID and index 0. If TRIGGER coincides with the end-of-sequence transition, the trigger wins: go to LOAD, not IDLE.
- A dur of 0 is not present in the ROM. If encountered, it is treated as 256 units (8-bit wrap).
- Note index wraps at 3 -> 0 only if no last flag is set. Every ROM effect sets last by entry 3.

Optional Feature:
- Macro SFX_PRIORITY_EN.
  - Defined: while BUSY, TRIGGER is ignored if EFFECT_ID < the latched ID; equal or higher IDs retrigger.
  - Undefined: every TRIGGER retriggers, as described above.
- In IDLE, the behaviour is identical either way.

Decomposition:
- Package sfx_pkg holds:
  - Note-entry struct (half, dur, last).
  - Effect-ID enum (PADDLE=0, BRICK=1, WALL=2, LIFE=3).
  - State enum (IDLE, LOAD, PLAY).
  - The 16-entry ROM constant array.
- Sub-module pulse_prescaler (parameter DIV; inputs CLK, RESET_N, CLEAR; output PULSE). Instantiated twice: free-running for ADVANCE_TICK, and cleared-on-LOAD for duration units.

Test Plan:
1. Bench uses TICK_DIV=4, DUR_DIV=10. Reset held 3 cycles -> all outputs 0. Release reset -> ADVANCE_TICK pulses every 4th cycle, one cycle wide.
2. TRIGGER with ID 0 -> BUSY next cycle. One LOAD cycle with enable 0, then HALF_PERIOD=1135 with enable 1 for exactly 300 cycles, then enable 0 and BUSY 0.
3. TRIGGER with ID 3 -> enable sequence is 1000 cycles high at 1135, 1 low (LOAD), 500 low (rest, HALF_PERIOD=0), 1 low, 1000 high at 1516, 1 low, 2000 high at 2272, then IDLE.
4. TRIGGER ID 3, then 150 cycles in TRIGGER ID 1 -> immediate LOAD, HALF_PERIOD=851 for 200 cycles, then 567 for 400 cycles. With SFX_PRIORITY_EN defined, the ID 1 trigger is ignored and effect 3 completes.
5. TRIGGER ID 2 asserted on the exact cycle effect 0's last note expires -> no IDLE cycle; LOAD, then HALF_PERIOD=1702 for 150 cycles.
6. RESET_N low for 1 cycle mid-note -> next cycle SYNTH_ENABLE=0, BUSY=0, HALF_PERIOD=0, ADVANCE_TICK phase restarted.

Source files
------------

// File: rtl/sfx_pkg.sv
// Shared types and note ROM for the sound-effect sequencer.
// The optional macro SFX_PRIORITY_EN is consumed by sfx_sequencer, not by this package.
package sfx_pkg;

  localparam int unsigned HALF_W    = 16;
  localparam int unsigned DUR_W     = 8;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned ROM_DEPTH = 16;

  // One note: synth half-period (0 = rest), length in duration units, end-of-effect flag
  typedef struct packed {
    logic [HALF_W-1:0] half;
    logic [DUR_W-1:0]  dur;
    logic              last;
  } note_t;

  typedef enum logic [ID_W-1:0] {
    PADDLE = 2'd0,
    BRICK  = 2'd1,
    WALL   = 2'd2,
    LIFE   = 2'd3
  } effect_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_e;

  // Indexed by {effect, note}; unreachable slots are silent single-unit terminators
  localparam note_t NOTE_ROM [ROM_DEPTH] = '{
    '{16'd1135, 8'd30,  1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd851,  8'd20,  1'b0},
    '{16'd567,  8'd40,  1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd1702, 8'd15,  1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd0,    8'd1,   1'b1},
    '{16'd1135, 8'd100, 1'b0},
    '{16'd0,    8'd50,  1'b0},
    '{16'd1516, 8'd100, 1'b0},
    '{16'd2272, 8'd200, 1'b1}
  };

endpackage

// File: rtl/pulse_prescaler.sv
// Wrapping 0..DIV-1 counter that strobes PULSE for the cycle it sits at DIV-1.
module pulse_prescaler #(
  parameter int unsigned DIV = 50
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CLEAR,
  output logic PULSE
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] count;

  // Count and wrap; CLEAR restarts the phase from 0 on the next cycle
  always_ff @(posedge CLK) begin
    if (!RESET_N || CLEAR) begin
      count <= '0;
    end else if (count == CNT_W'(DIV - 1)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign PULSE = (count == CNT_W'(DIV - 1));

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays ROM note lists into the square-wave synth.
// Optional macro SFX_PRIORITY_EN: while busy, a trigger with a lower effect ID is ignored.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned DUR_DIV  = 50000
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              TRIGGER,
  input  logic [ID_W-1:0]   EFFECT_ID,
  output logic [HALF_W-1:0] HALF_PERIOD,
  output logic              SYNTH_ENABLE,
  output logic              ADVANCE_TICK,
  output logic              BUSY
);

  state_e           state;
  effect_e          id;
  logic [IDX_W-1:0] idx;
  logic [DUR_W-1:0] dur_cnt;
  note_t            note;
  logic             dur_pulse;
  logic             dur_clear;
  logic             accept;

  assign note      = NOTE_ROM[{id, idx}];
  assign dur_clear = (state == LOAD);

`ifdef SFX_PRIORITY_EN
  // Lower-ID requests cannot interrupt a playing effect
  assign accept = TRIGGER && ((state == IDLE) || (EFFECT_ID >= ID_W'(id)));
`else
  assign accept = TRIGGER;
`endif

  // Free-running synth tick
  pulse_prescaler #(.DIV(TICK_DIV)) u_tick (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLEAR   (1'b0),
    .PULSE   (ADVANCE_TICK)
  );

  // Duration-unit strobe, phase-aligned to the start of each note
  pulse_prescaler #(.DIV(DUR_DIV)) u_dur (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLEAR   (dur_clear),
    .PULSE   (dur_pulse)
  );

  // Sequencer FSM with registered synth-side outputs; an accepted trigger wins over everything
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state        <= IDLE;
      id           <= PADDLE;
      idx          <= '0;
      dur_cnt      <= '0;
      HALF_PERIOD  <= '0;
      SYNTH_ENABLE <= 1'b0;
      BUSY         <= 1'b0;
    end else if (accept) begin
      state        <= LOAD;
      id           <= effect_e'(EFFECT_ID);
      idx          <= '0;
      SYNTH_ENABLE <= 1'b0;
      BUSY         <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          HALF_PERIOD  <= note.half;
          dur_cnt      <= note.dur;
          SYNTH_ENABLE <= (note.half != '0);
          state        <= PLAY;
        end
        PLAY: begin
          if (dur_pulse) begin
            // dur of 0 decrements through 255 and so lasts 256 units
            if (dur_cnt == DUR_W'(1)) begin
              SYNTH_ENABLE <= 1'b0;
              if (note.last) begin
                state <= IDLE;
                BUSY  <= 1'b0;
              end else begin
                state <= LOAD;
                idx   <= idx + IDX_W'(1);
              end
            end else begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end
          end
        end
        default: begin
          SYNTH_ENABLE <= 1'b0;
          BUSY         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: a timeline model pushes expected per-cycle
// outputs, an independent monitor pops and compares on every falling edge.
module tb_sfx_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DUR_DIV  = 10;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        TRIGGER = 1'b0;
  logic [1:0]  EFFECT_ID = 2'd0;
  logic [15:0] HALF_PERIOD;
  logic        SYNTH_ENABLE;
  logic        ADVANCE_TICK;
  logic        BUSY;

  always #5 clk = ~clk;

  sfx_sequencer #(.TICK_DIV(TICK_DIV), .DUR_DIV(DUR_DIV)) dut (
    .CLK          (clk),
    .RESET_N      (RESET_N),
    .TRIGGER      (TRIGGER),
    .EFFECT_ID    (EFFECT_ID),
    .HALF_PERIOD  (HALF_PERIOD),
    .SYNTH_ENABLE (SYNTH_ENABLE),
    .ADVANCE_TICK (ADVANCE_TICK),
    .BUSY         (BUSY)
  );

  typedef struct packed {
    logic [15:0] half;
    logic        en;
    logic        busy;
    logic        tick;
  } obs_t;

  // Effect table: note half-periods and durations in units
  int eff_len  [4]    = '{1, 2, 1, 4};
  int eff_half [4][4] = '{'{1135, 0, 0, 0}, '{851, 567, 0, 0}, '{1702, 0, 0, 0}, '{1135, 0, 1516, 2272}};
  int eff_dur  [4][4] = '{'{30, 0, 0, 0}, '{20, 40, 0, 0}, '{15, 0, 0, 0}, '{100, 50, 100, 200}};

  obs_t        sb[$];
  obs_t        plan[$];
  logic [15:0] m_half = 16'd0;
  logic        m_en   = 1'b0;
  logic        m_busy = 1'b0;
  int          m_phase = 0;
  int          lat_id  = 0;
  int          passed  = 0;
  int          total   = 0;
  int          cyc     = 0;
  obs_t        exp_o, got_o;

  // Timeline of an effect: a silent LOAD cycle before each note, then dur*DUR_DIV cycles of it
  function automatic void build_plan(input int e);
    logic [15:0] h;
    obs_t        o;
    h = m_half;
    plan.delete();
    for (int k = 0; k < eff_len[e]; k++) begin
      o = '{h, 1'b0, 1'b1, 1'b0};
      plan.push_back(o);
      h = 16'(eff_half[e][k]);
      for (int c = 0; c < eff_dur[e][k] * int'(DUR_DIV); c++) begin
        o = '{h, (h != 16'd0), 1'b1, 1'b0};
        plan.push_back(o);
      end
    end
  endfunction

  // Advance the model by one clock edge and queue the expected outputs for the following cycle
  task automatic model_step(input logic rst, input logic trig, input logic [1:0] id);
    obs_t e;
    bit   acc;
    if (!rst) begin
      plan.delete();
      m_half  = 16'd0;
      m_en    = 1'b0;
      m_busy  = 1'b0;
      m_phase = 0;
    end else begin
      m_phase = (m_phase + 1) % int'(TICK_DIV);
      acc = trig;
`ifdef SFX_PRIORITY_EN
      if (m_busy && int'(id) < lat_id) acc = 1'b0;
`endif
      if (acc) begin
        lat_id = int'(id);
        build_plan(int'(id));
      end
      if (plan.size() > 0) begin
        e = plan.pop_front();
        m_half = e.half;
        m_en   = e.en;
        m_busy = e.busy;
      end else begin
        m_en   = 1'b0;
        m_busy = 1'b0;
      end
    end
    e = '{m_half, m_en, m_busy, (m_phase == int'(TICK_DIV) - 1)};
    sb.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic trig, input logic [1:0] id);
    RESET_N   = rst;
    TRIGGER   = trig;
    EFFECT_ID = id;
    @(posedge clk);
    model_step(rst, trig, id);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0);
  endtask

  // Directed point check
  task automatic check(input bit ok, input string what);
    total++;
    if (ok) begin
      passed++;
    end else begin
      $display("FAIL %s: half=%0d en=%b busy=%b tick=%b",
               what, HALF_PERIOD, SYNTH_ENABLE, BUSY, ADVANCE_TICK);
    end
  endtask

  // Monitor: compare whatever the DUT shows against the next queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_o = sb.pop_front();
        got_o = {HALF_PERIOD, SYNTH_ENABLE, BUSY, ADVANCE_TICK};
        cyc++;
        total++;
        if (got_o === exp_o) begin
          passed++;
        end else begin
          $display("FAIL outputs cyc=%0d got half=%0d en=%b busy=%b tick=%b expected half=%0d en=%b busy=%b tick=%b",
                   cyc, got_o.half, got_o.en, got_o.busy, got_o.tick,
                   exp_o.half, exp_o.en, exp_o.busy, exp_o.tick);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random triggers and occasional resets
  initial begin
    logic       r;
    logic       t;
    logic [1:0] id;
    #1;
    repeat (3) cycle(1'b0, 1'b0, 2'd0);
    check((HALF_PERIOD === 16'd0) && (SYNTH_ENABLE === 1'b0) &&
          (BUSY === 1'b0) && (ADVANCE_TICK === 1'b0), "reset state");
    idle(12);
    // Single short effect
    cycle(1'b1, 1'b1, 2'd0);
    idle(310);
    check((HALF_PERIOD === 16'd1135) && (SYNTH_ENABLE === 1'b0) &&
          (BUSY === 1'b0), "effect 0 expired");
    // Four-note effect with a rest
    cycle(1'b1, 1'b1, 2'd3);
    idle(4560);
    // Retrigger with a lower ID mid-note
    cycle(1'b1, 1'b1, 2'd3);
    idle(149);
    cycle(1'b1, 1'b1, 2'd1);
    idle(4600);
    // Trigger exactly on the final note's expiry edge
    cycle(1'b1, 1'b1, 2'd0);
    idle(300);
    cycle(1'b1, 1'b1, 2'd2);
    idle(200);
    // Reset mid-note
    cycle(1'b1, 1'b1, 2'd3);
    idle(50);
    cycle(1'b0, 1'b0, 2'd0);
    idle(20);
    // Random traffic
    for (int i = 0; i < 8000; i++) begin
      r  = ($urandom_range(0, 2999) != 0);
      t  = ($urandom_range(0, 149) == 0);
      id = 2'($urandom_range(0, 3));
      cycle(r, t, id);
    end
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
